duck_sprite_fetch: RTL and testbench

Per-pixel sprite fetch stage for one duck. From the current VGA scan position, the duck's screen position and its animation state, it generates the duck sprite ROM address and registers the returned 4-bit colour index. It then drives that index, with an opacity flag, to the duck palette lookup directly downstream. It also owns the duck's flap/shot/fall animation sequencing, advanced once per video frame.

---
 rtl/duck_pkg.sv | 26 ++
 rtl/duck_anim_fsm.sv | 108 ++++++++++
 rtl/duck_sprite_fetch.sv | 95 +++++++++
 tb/tb_duck_sprite_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite path: animation states,
// ROM frame numbers, the transparent colour key and the sprite ROM address width.
package duck_pkg;

  typedef enum logic [1:0] {
    FLY  = 2'd0,
    SHOT = 2'd1,
    FALL = 2'd2
  } anim_state_e;

  localparam logic [2:0] FR_FLAP0 = 3'd0;
  localparam logic [2:0] FR_FLAP1 = 3'd1;
  localparam logic [2:0] FR_FLAP2 = 3'd2;
  localparam logic [2:0] FR_SHOT  = 3'd3;
  localparam logic [2:0] FR_FALL0 = 3'd4;
  localparam logic [2:0] FR_FALL1 = 3'd5;

  // Six 32x32 frames of 4-bit pixels.
  localparam int ROM_AW = 13;

  // Background key colours drawn by the artist; these are never opaque.
  function automatic logic is_transparent(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd5) || (idx == 4'd10) || (idx == 4'd14);
  endfunction

endpackage

// File: rtl/duck_anim_fsm.sv
// Duck flap/shot/fall sequencer. Hit and respawn are latched when they occur
// and only acted on at frame_tick, so the visible frame never changes mid-scan.
module duck_anim_fsm
  import duck_pkg::*;
#(
  parameter int FLAP_DIV  = 8,
  parameter int SHOT_HOLD = 30
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        duck_hit,
  input  logic        respawn,
  output logic [2:0]  frame,
  output anim_state_e anim_state
);

  localparam int CNT_MAX = (SHOT_HOLD > FLAP_DIV) ? SHOT_HOLD : FLAP_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FLAP_LAST = CNT_W'(FLAP_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SHOT_HOLD - 1);

  anim_state_e      state_q, state_d;
  logic [2:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_pend_q, hit_pend_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic             hit_eff, rsp_eff;

  assign hit_eff = duck_hit | hit_pend_q;
  assign rsp_eff = respawn  | rsp_pend_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    hit_pend_d = hit_eff;
    rsp_pend_d = rsp_eff;
    if (frame_tick) begin
      hit_pend_d = 1'b0;
      rsp_pend_d = 1'b0;
      if (rsp_eff) begin
        state_d = FLY;
        frame_d = FR_FLAP0;
        cnt_d   = '0;
      end else if (hit_eff && state_q == FLY) begin
        state_d = SHOT;
        frame_d = FR_SHOT;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          FLY: begin
            if (cnt_q == FLAP_LAST) begin
              cnt_d   = '0;
              frame_d = (frame_q == FR_FLAP2) ? FR_FLAP0 : 3'(frame_q + 3'd1);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          SHOT: begin
            if (cnt_q == HOLD_LAST) begin
              state_d = FALL;
              frame_d = FR_FALL0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          FALL: begin
            if (cnt_q == FLAP_LAST) begin
              cnt_d   = '0;
              frame_d = (frame_q == FR_FALL0) ? FR_FALL1 : FR_FALL0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = FLY;
            frame_d = FR_FLAP0;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= FLY;
      frame_q    <= FR_FLAP0;
      cnt_q      <= '0;
      hit_pend_q <= 1'b0;
      rsp_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      hit_pend_q <= hit_pend_d;
      rsp_pend_q <= rsp_pend_d;
    end
  end

  assign frame      = frame_q;
  assign anim_state = state_q;

endmodule

// File: rtl/duck_sprite_fetch.sv
// Duck sprite fetch: hit test, ROM address, 3-cycle pixel pipeline to the palette.
// Optional horizontal mirroring by duck_dir when DUCK_MIRROR_EN is defined.
module duck_sprite_fetch
  import duck_pkg::*;
#(
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int FLAP_DIV  = 8,
  parameter int SHOT_HOLD = 30
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic              duck_dir,
  input  logic              duck_hit,
  input  logic              respawn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              pix_valid,
  output logic [1:0]        anim_state
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  logic [2:0]        frame;
  anim_state_e       state;
  logic signed [10:0] rel_x, rel_y;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              inside_c, opaque_c;
  logic [ROM_AW-1:0] addr_c;
  logic              in_s1, in_s2;

  duck_anim_fsm #(
    .FLAP_DIV  (FLAP_DIV),
    .SHOT_HOLD (SHOT_HOLD)
  ) u_fsm (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .duck_hit   (duck_hit),
    .respawn    (respawn),
    .frame      (frame),
    .anim_state (state)
  );

  assign rel_x = $signed({1'b0, draw_x}) - $signed({1'b0, duck_x});
  assign rel_y = $signed({1'b0, draw_y}) - $signed({1'b0, duck_y});

  // Upper bits all zero means non-negative and below the sprite size, so a
  // duck near the right edge never wraps onto column 0.
  assign inside_c = blank && (rel_x[10:CW] == '0) && (rel_y[10:RW] == '0);
  assign row      = rel_y[RW-1:0];

`ifdef DUCK_MIRROR_EN
  // Width is a power of two, so SPR_W-1-rel_x is the bitwise inverse.
  assign col = duck_dir ? ~rel_x[CW-1:0] : rel_x[CW-1:0];
`else
  logic unused_dir;
  assign unused_dir = duck_dir;
  assign col        = rel_x[CW-1:0];
`endif

  assign addr_c = ROM_AW'(frame) * ROM_AW'(SPR_W * SPR_H)
                + ROM_AW'(row) * ROM_AW'(SPR_W)
                + ROM_AW'(col);

  assign opaque_c = in_s2 && !is_transparent(rom_data);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr  <= '0;
      in_s1     <= 1'b0;
      in_s2     <= 1'b0;
      pix_index <= 4'd0;
      pix_valid <= 1'b0;
    end else begin
      rom_addr  <= addr_c;
      in_s1     <= inside_c;
      in_s2     <= in_s1;
      pix_valid <= opaque_c;
      pix_index <= opaque_c ? rom_data : 4'd0;
    end
  end

  assign anim_state = state;

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Randomised bench for duck_sprite_fetch against a frame-count animation model
// and a direct pixel/ROM model; expected pixels travel through a 3-deep queue.
module tb_duck_sprite_fetch;

  localparam int FLAP = 8;
  localparam int HOLD = 30;
`ifdef DUCK_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic        vga_clk = 1'b0;
  logic        reset, frame_tick, blank, duck_dir, duck_hit, respawn;
  logic [9:0]  draw_x, draw_y, duck_x, duck_y;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data, pix_index;
  logic        pix_valid;
  logic [1:0]  anim_state;

  logic [3:0]  rom [0:8191];

  int tests = 0;
  int fails = 0;

  // Animation model: ticks elapsed since the last hit/respawn/reset.
  bit m_shot, m_hit_p, m_rsp_p;
  int m_n;
  int q_valid[$];
  int q_index[$];

  duck_sprite_fetch dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .blank      (blank),
    .duck_x     (duck_x),
    .duck_y     (duck_y),
    .duck_dir   (duck_dir),
    .duck_hit   (duck_hit),
    .respawn    (respawn),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_valid  (pix_valid),
    .anim_state (anim_state)
  );

  always #5 vga_clk = ~vga_clk;

  always_ff @(posedge vga_clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_frame();
    if (!m_shot) return (m_n / FLAP) % 3;
    if (m_n < HOLD) return 3;
    return 4 + ((m_n - HOLD) / FLAP) % 2;
  endfunction

  function automatic int m_anim();
    if (!m_shot) return 0;
    return (m_n < HOLD) ? 1 : 2;
  endfunction

  task automatic model_tick();
    if (m_rsp_p) begin
      m_shot = 1'b0;
      m_n    = 0;
    end else if (m_hit_p && !m_shot) begin
      m_shot = 1'b1;
      m_n    = 0;
    end else begin
      m_n++;
    end
    m_hit_p = 1'b0;
    m_rsp_p = 1'b0;
  endtask

  task automatic step(input int x, input int y, input bit blk, input bit tick,
                      input bit hit, input bit rsp);
    int  rx, ry, col, addr, idx, ev, ei;
    bit  ins, op;
    draw_x     = 10'(x);
    draw_y     = 10'(y);
    blank      = blk;
    frame_tick = tick;
    duck_hit   = hit;
    respawn    = rsp;
    rx   = x - int'(duck_x);
    ry   = y - int'(duck_y);
    ins  = blk && rx >= 0 && rx < 32 && ry >= 0 && ry < 32;
    col  = (MIRROR && duck_dir) ? 31 - rx : rx;
    addr = m_frame() * 1024 + ry * 32 + col;
    idx  = ins ? int'(rom[addr]) : 0;
    op   = ins && !(idx inside {0, 5, 10, 14});
    q_valid.push_back(op ? 1 : 0);
    q_index.push_back(op ? idx : 0);
    if (hit) m_hit_p = 1'b1;
    if (rsp) m_rsp_p = 1'b1;
    @(posedge vga_clk);
    #1;
    if (ins) check("rom_addr", rom_addr, addr);
    if (tick) begin
      model_tick();
      check("anim_state", anim_state, m_anim());
    end
    if (q_valid.size() == 3) begin
      ev = q_valid.pop_front();
      ei = q_index.pop_front();
      check("pix_valid", pix_valid, ev);
      check("pix_index", pix_index, ei);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    frame_tick = 1'b0;
    blank      = 1'b0;
    duck_hit   = 1'b0;
    respawn    = 1'b0;
    @(posedge vga_clk);
    #1;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_index", pix_index, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_anim_state", anim_state, 0);
    reset = 1'b0;
    m_shot = 1'b0; m_n = 0; m_hit_p = 1'b0; m_rsp_p = 1'b0;
    q_valid.delete();
    q_index.delete();
    // The two flushed pipeline stages must emerge as zeros.
    repeat (2) begin
      q_valid.push_back(0);
      q_index.push_back(0);
    end
  endtask

  task automatic scan_line(input int y, input int x0, input int x1, input int hit_x);
    for (int x = x0; x <= x1; x++) step(x & 1023, y, 1'b1, 1'b0, x == hit_x, 1'b0);
    step(0, y, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'd5;
    rom[1] = 4'd3;
    duck_x = 10'd100; duck_y = 10'd50; duck_dir = 1'b0;
    draw_x = '0; draw_y = '0;
    do_reset();

    // Full sprite box plus margin, frame 0.
    for (int y = 46; y <= 85; y++) scan_line(y, 96, 135, -1);

    // 24 ticks of flight, one line scanned per frame.
    for (int t = 0; t < 24; t++) begin
      tick();
      scan_line(50 + t, 98, 133, -1);
    end

    // Hit mid-line, a second hit ignored, then hold and fall.
    scan_line(60, 96, 135, 116);
    scan_line(61, 96, 135, -1);
    tick();
    scan_line(62, 96, 135, -1);
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 45; t++) begin
      tick();
      scan_line(50 + (t % 32), 98, 133, -1);
    end

    // Respawn, then hit and respawn together.
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    scan_line(55, 98, 133, -1);
    repeat (3) tick();
    step(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      tick();
      scan_line(70, 98, 133, -1);
    end

    // Duck against the right edge: no wrap onto column 0.
    duck_x = 10'd1020; duck_y = 10'd50;
    for (int y = 50; y < 54; y++) begin
      scan_line(y, 0, 11, -1);
      scan_line(y, 1016, 1023, -1);
    end

    // Randomised positions, direction, events and ticks.
    for (int s = 0; s < 40; s++) begin
      int dx, dy;
      dx = (s % 4 == 0) ? 1020 : $urandom_range(0, 1023);
      dy = $urandom_range(0, 1023);
      duck_x   = 10'(dx);
      duck_y   = 10'(dy);
      duck_dir = 1'($urandom_range(0, 1));
      step(0, 0, 1'b0, 1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      for (int i = 0; i < 60; i++)
        step((dx - 4 + $urandom_range(0, 40)) & 1023, (dy - 2 + $urandom_range(0, 36)) & 1023,
             $urandom_range(0, 9) != 0, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(1, 9)) tick();
    end

    // Reset in the middle of an active line.
    duck_x = 10'd100; duck_y = 10'd50; duck_dir = 1'b0;
    for (int x = 96; x < 116; x++) step(x, 51, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int x = 116; x < 136; x++) step(x, 51, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
